ppg_reduce_acc: RTL
===================

// Module: ppg_reduce_acc
// PURPOSE
//  Consumes Booth radix-4 partial products from N PPG instances (one per kernel tap) and reduces them.
//  Each lane's pp0..pp3/neg0..neg3 are summed, and N*K1 sign-extension correction is added.
//  Beats are accumulated over a packet (e.g. input channels); one signed sum per packet is emitted.
//  Sits directly downstream of the PPG array and feeds the activation/requant stage. Valid/ready both sides.
// PARAMETERS
//  N      9   lanes (PPG instances) per beat
//  BEAT_W 19  corrected per-beat sum width, two's complement (holds 9*16384)
//  ACC_W  24  accumulator/output width, two's complement, >= BEAT_W
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-low reset
//  in_valid   in   1        beat valid
//  in_ready   out  1        beat accepted when in_valid&&in_ready at rising edge
//  in_last    in   1        final beat of packet
//  pp0_bus    in   N*11     lane i pp0 at [11i+10:11i]
//  pp1_bus    in   N*9      lane i pp1 at [9i+8:9i]; pp2_bus, pp3_bus identical layout
//  pp2_bus    in   N*9      see pp1_bus
//  pp3_bus    in   N*9      see pp1_bus
//  neg_bus    in   N*4      lane i {neg3,neg2,neg1,neg0} at [4i+3:4i]
//  out_valid  out  1        packet result valid, held until out_ready
//  out_ready  in   1        consumer accept
//  out_sum    out  ACC_W    signed packet sum
//  out_ovf    out  1        sticky per-packet signed overflow of accumulator
// BEHAVIOUR
//  - Lane value (unsigned, mod 2^BEAT_W): pp0 + pp1<<2 + pp2<<4 + pp3<<6 + neg0 + neg1<<2 + neg2<<4 + neg3<<6.
//  - Beat sum = (sum of N lane values + N*K1) mod 2^BEAT_W, read as signed. K1=19'h7A800 (N=9 -> 19'h4E800).
//    Equals sum over lanes of multiplier*multiplicand (signed 8x8).
//  - Pipeline: S1 regs N lane values | S2 reg corrected beat sum + last flag + valid | S3 accumulator/output.
//  - Global enable en = !out_valid || out_ready; in_ready = en. en=0 freezes S1/S2/acc/out; in-flight beats are kept.
//  - Latency: beat accepted at edge k -> S1 @k, S2 @k+1, committed @k+2.
//    For a last beat, out_valid is high after edge k+2; single-beat packet gives 3 edges in -> out.
//  - Commit of non-last beat: acc <= acc + sext(beat); ovf_acc |= signed overflow.
//  - Commit of last beat: out_sum <= acc + sext(beat); out_ovf <= ovf_acc | overflow; out_valid <= 1; acc, ovf_acc <= 0.
//  - out_valid&&out_ready with no new last commit: out_valid <= 0, out_sum/out_ovf hold value.
//  - Same-edge handoff: when out_ready is high and a last beat commits, the new result replaces the old.
//    out_valid stays 1, giving full throughput with no bubble.
//  - Overflow: accumulator wraps mod 2^ACC_W; ovf flags only, no saturation.
//  - Bubbles: S2 valid=0 commits nothing, and acc is unchanged.
//  - Packets are back-to-back; a beat after a last beat starts a fresh accumulation.
//  - Reset (async assert, any time incl. mid-packet): S1/S2 valid=0, acc=0, ovf_acc=0, out_valid=0, out_sum=0, out_ovf=0.
//    in_ready is 1 after reset. Partial packets are discarded.
//    Release is sync to clk; the first beat can be accepted at the first edge after release.
// STRUCTURE
//  - Package ppg_pkg: PP0_W=11, PP_W=9, NEG_W=4, BEAT_W=19, K1=19'h7A800, function corr(n)=n*K1 mod 2^BEAT_W.
//    Shared with PPG and its bench.
//  - Sub-module ppg_lane_sum: combinational single-lane weighted sum (pp0..3, neg0..3 -> BEAT_W).
//    Instantiated N times in a generate loop ahead of S1.
//  - Top holds the adder tree (S1->S2), the accumulator/output FSM, and handshake logic.
//    Output side is effectively 2 states: IDLE (out_valid=0) and HOLD (out_valid=1).
// TESTING (drive inputs through N real PPG instances; reference = signed a*b sums)
//  - 1 beat, all 9 lanes a=-128,b=-128, last=1 -> out_sum=147456, out_ovf=0, out_valid 3 edges after accept.
//  - 1 beat, lane0 a=3,b=-5, other lanes 0 -> out_sum=-15; then lane0 sweep over all 65536 (a,b) pairs.
//    Each must give a*b, with 0 mismatches.
//  - 3-beat packet, all lanes a=127,b=-128 each beat -> out_sum=-438912; next 1-beat packet of zeros -> 0.
//  - Back-to-back 1-beat packets; out_ready low for 5 cycles mid-stream.
//    in_ready must drop, no beat lost or duplicated, results in order, out_sum stable while held.
//  - Assert reset after 2 beats of a 4-beat packet, then release.
//    All outputs 0 immediately; a following 1-beat packet (lane0 7*7) -> 49.
//  - ACC_W=20, 4 beats of all-lanes -128*-128 -> out_ovf=1, out_sum=589824 mod 2^20 read as signed = -458752.
//    Next packet gives out_ovf=0.

Source files
------------

// File: rtl/ppg_pkg.sv
// Shared widths and sign-extension correction constant for the Booth radix-4 PPG
// datapath and its reduction stage.
package ppg_pkg;

  localparam int unsigned PP0_W  = 11;
  localparam int unsigned PP_W   = 9;
  localparam int unsigned NEG_W  = 4;
  localparam int unsigned BEAT_W = 19;

  localparam logic [BEAT_W-1:0] K1 = 19'h7A800;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic {
    OUT_IDLE,
    OUT_HOLD
  } out_state_e;

  // Correction for n lanes: cancels the folded sign-extension offset of every lane.
  function automatic beat_t corr(input int unsigned n);
    return beat_t'(n * 32'(K1));
  endfunction

endpackage

// File: rtl/ppg_lane_sum.sv
// Combinational weighted sum of one PPG lane: pp0..pp3 and neg0..neg3 at radix-4 weights,
// taken modulo 2^BEAT_W.
module ppg_lane_sum
  import ppg_pkg::*;
(
  input  logic [PP0_W-1:0]  i_pp0,
  input  logic [PP_W-1:0]   i_pp1,
  input  logic [PP_W-1:0]   i_pp2,
  input  logic [PP_W-1:0]   i_pp3,
  input  logic [NEG_W-1:0]  i_neg,
  output logic [BEAT_W-1:0] o_sum
);

  always_comb begin
    o_sum = BEAT_W'(i_pp0)
          + (BEAT_W'(i_pp1) << 2)
          + (BEAT_W'(i_pp2) << 4)
          + (BEAT_W'(i_pp3) << 6)
          + BEAT_W'(i_neg[0])
          + (BEAT_W'(i_neg[1]) << 2)
          + (BEAT_W'(i_neg[2]) << 4)
          + (BEAT_W'(i_neg[3]) << 6);
  end

endmodule

// File: rtl/ppg_reduce_acc.sv
// Reduces N lanes of Booth partial products to a corrected signed beat sum and
// accumulates beats into one signed result per packet, valid/ready on both sides.
module ppg_reduce_acc
  import ppg_pkg::*;
#(
  parameter int unsigned N     = 9,
  parameter int unsigned ACC_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [N*PP0_W-1:0] pp0_bus,
  input  logic [N*PP_W-1:0]  pp1_bus,
  input  logic [N*PP_W-1:0]  pp2_bus,
  input  logic [N*PP_W-1:0]  pp3_bus,
  input  logic [N*NEG_W-1:0] neg_bus,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf
);

  logic              w_en;
  logic [BEAT_W-1:0] w_lane [N];
  logic [BEAT_W-1:0] w_tree;
  logic [ACC_W-1:0]  w_beat_ext;
  logic [ACC_W-1:0]  w_next;
  logic              w_ovf;

  logic [BEAT_W-1:0] r_lane [N];
  logic              r_s1_valid;
  logic              r_s1_last;
  logic [BEAT_W-1:0] r_beat;
  logic              r_s2_valid;
  logic              r_s2_last;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf_acc;
  out_state_e        r_state;

  for (genvar g = 0; g < int'(N); g++) begin : g_lane
    ppg_lane_sum u_lane (
      .i_pp0 (pp0_bus[g*PP0_W +: PP0_W]),
      .i_pp1 (pp1_bus[g*PP_W +: PP_W]),
      .i_pp2 (pp2_bus[g*PP_W +: PP_W]),
      .i_pp3 (pp3_bus[g*PP_W +: PP_W]),
      .i_neg (neg_bus[g*NEG_W +: NEG_W]),
      .o_sum (w_lane[g])
    );
  end

  // A held result that is not being taken stalls the whole pipe.
  assign w_en      = (r_state == OUT_IDLE) || out_ready;
  assign in_ready  = w_en;
  assign out_valid = (r_state == OUT_HOLD);

  always_comb begin
    w_tree = corr(N);
    for (int unsigned i = 0; i < N; i++) begin
      w_tree = w_tree + r_lane[i];
    end
  end

  always_comb begin
    w_beat_ext = ACC_W'($signed(r_beat));
    w_next     = r_acc + w_beat_ext;
    w_ovf      = (r_acc[ACC_W-1] == w_beat_ext[ACC_W-1]) &&
                 (w_next[ACC_W-1] != r_acc[ACC_W-1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane     <= '{default: '0};
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_beat     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_acc      <= '0;
      r_ovf_acc  <= 1'b0;
      r_state    <= OUT_IDLE;
      out_sum    <= '0;
      out_ovf    <= 1'b0;
    end else if (w_en) begin
      r_lane     <= w_lane;
      r_s1_valid <= in_valid;
      r_s1_last  <= in_last;
      r_beat     <= w_tree;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      // A last-beat commit wins over the drain, so a consumed result is replaced in place.
      if (r_s2_valid && r_s2_last) begin
        out_sum   <= w_next;
        out_ovf   <= r_ovf_acc | w_ovf;
        r_state   <= OUT_HOLD;
        r_acc     <= '0;
        r_ovf_acc <= 1'b0;
      end else begin
        if (r_s2_valid) begin
          r_acc     <= w_next;
          r_ovf_acc <= r_ovf_acc | w_ovf;
        end
        if (r_state == OUT_HOLD) begin
          r_state <= OUT_IDLE;
        end
      end
    end
  end

endmodule
